display_scan_driver: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment display, downstream of the 16-bit display-source mux.
- Captures a 16-bit value (four hex nibbles) plus a 4-bit decimal-point mask.
- Applies a new capture only at a frame boundary, so the display never tears.
- Scans one digit at a time with a blanking gap (anti-ghosting) and emits active-low anode, segment and dp drives.

---
 rtl/display_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_display_scan_driver.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with frame-aligned value updates.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (1..3).
module display_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  decimal_point,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIG_W = 2;
  localparam int unsigned SEG_W = 7;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NDIG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] d_q, d_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d;
  logic [NDIG-1:0]  pend_dp_q, pend_dp_d;
  logic             pend_flag_q, pend_flag_d;
  logic [VAL_W-1:0] act_val_q, act_val_d;
  logic [NDIG-1:0]  act_dp_q, act_dp_d;

  logic [NDIG-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;

  logic             slot_end;
  logic             boundary;
  logic             lead_blank;
  logic [3:0]       cur_nib;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (d_q == DIG_LAST);
  assign cur_nib  = act_val_q[{d_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is hidden only if it and every digit to its left is zero with no dp lit.
  always_comb begin
    lead_blank = 1'b0;
    case (d_q)
      2'd1:    lead_blank = (act_val_q[15:4]  == 12'h000) && (act_dp_q[3:1] == 3'b000);
      2'd2:    lead_blank = (act_val_q[15:8]  == 8'h00)   && (act_dp_q[3:2] == 2'b00);
      2'd3:    lead_blank = (act_val_q[15:12] == 4'h0)    && (act_dp_q[3]   == 1'b0);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Next-state for counters, pending/active capture and the registered drives.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    d_d         = d_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    an_d        = '1;
    seg_d       = '1;
    dp_d        = 1'b1;
    tick_d      = 1'b0;

    if (slot_end) begin
      cnt_d = '0;
      d_d   = d_q + DIG_W'(1);
    end

    if (load) begin
      pend_val_d  = value;
      pend_dp_d   = decimal_point;
      pend_flag_d = 1'b1;
    end

    // Frame boundary: a same-cycle load bypasses the pending copy.
    if (boundary) begin
      tick_d      = 1'b1;
      pend_flag_d = 1'b0;
      if (load) begin
        act_val_d = value;
        act_dp_d  = decimal_point;
      end else if (pend_flag_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
    end

    if ((cnt_q >= CNT_BLANK) && !lead_blank) begin
      an_d  = ~(NDIG'(1) << d_q);
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~act_dp_q[d_q];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      d_q         <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: directed scenarios plus random loads against a time-indexed model.
module tb_display_scan_driver;

  localparam int unsigned RD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = RD * 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic [3:0]  decimal_point;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int tests;
  int fails;

  // Reference model: display position derived from edges since reset release.
  int unsigned cyc;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pend_v;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;
  int unsigned e_pos, e_dig;

  display_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .decimal_point(decimal_point),
    .load(load), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic digit_hidden(input int unsigned i);
`ifdef LEADING_ZERO_BLANK_EN
    return (i > 0) && ((m_act >> (4 * i)) == 16'h0) && ((m_act_dp >> i) == 4'h0);
`else
    return (i > 99);
`endif
  endfunction

  task automatic model_reset();
    cyc = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pend_v = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load = 1'b0; value = '0; decimal_point = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Predict the outputs of the coming edge, advance the model, then move past the edge.
  task automatic step();
    e_pos  = cyc % RD;
    e_dig  = (cyc / RD) % 4;
    e_tick = (e_pos == RD - 1) && (e_dig == 3);
    if (e_pos < BC || digit_hidden(e_dig)) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << e_dig);
      e_seg = seg_of(m_act[4*e_dig +: 4]);
      e_dp  = ~m_act_dp[e_dig];
    end
    if (e_tick) begin
      if (load) begin m_act = value; m_act_dp = decimal_point; end
      else if (m_pend_v) begin m_act = m_pend; m_act_dp = m_pend_dp; end
      m_pend_v = 1'b0;
    end else if (load) begin
      m_pend = value; m_pend_dp = decimal_point; m_pend_v = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int unsigned phase);
    while (cyc % FRAME != phase) step();
  endtask

  task automatic test_reset();
    int ticks;
    do_reset();
    if ({an, seg, dp, frame_tick} !== 13'b1111_1111111_1_0) begin
      fails++; $display("FAIL reset_vals got an=%b seg=%b dp=%b tick=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    tests++;
    for (int k = 0; k < 2; k++) begin
      step();
      if (an !== 4'b1111) begin
        fails++; $display("FAIL reset_blank cyc=%0d got an=%b want 1111", cyc, an);
      end
      tests++;
    end
    step();
    if ({an, seg, dp} !== 12'b1110_1000000_1) begin
      fails++; $display("FAIL first_digit got an=%b seg=%b dp=%b want 1110 1000000 1", an, seg, dp);
    end
    tests++;
    ticks = 0;
    for (int k = 0; k < 61; k++) begin
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL reset_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
      if (frame_tick) ticks++;
    end
    if (ticks != 2) begin
      fails++; $display("FAIL tick_period got %0d ticks want 2", ticks);
    end
    tests++;
  endtask

  task automatic test_load_mid_frame();
    logic [6:0] c_seg [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    logic       c_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    advance_to(10);
    load = 1'b1; value = 16'h12AF; decimal_point = 4'b0010;
    step();
    load = 1'b0;
    while (cyc % FRAME != 0) begin
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL midload_hold cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
    end
    if (frame_tick !== 1'b1) begin
      fails++; $display("FAIL midload_tick got %b want 1", frame_tick);
    end
    tests++;
    for (int k = 0; k < int'(FRAME); k++) begin
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL midload_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
      if (e_pos == 4) begin
        if ({an, seg, dp} !== {~(4'b0001 << e_dig), c_seg[e_dig], c_dp[e_dig]}) begin
          fails++; $display("FAIL midload_digit d=%0d got an=%b seg=%b dp=%b want seg=%b dp=%b", e_dig, an, seg, dp, c_seg[e_dig], c_dp[e_dig]);
        end
        tests++;
      end
    end
  endtask

  task automatic test_last_wins();
    logic in_new;
    do_reset();
    advance_to(5);
    load = 1'b1; value = 16'h1111; decimal_point = 4'b0000;
    step();
    load = 1'b0;
    advance_to(15);
    load = 1'b1; value = 16'h2222;
    step();
    load = 1'b0;
    in_new = 1'b0;
    for (int k = 0; k < int'(FRAME) + 16; k++) begin
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL lastwins_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
      if (seg === 7'b1111001) begin
        fails++; $display("FAIL lastwins_stale cyc=%0d got seg=%b which must never appear", cyc, seg);
      end
      tests++;
      if (in_new && e_pos == 4) begin
        if (seg !== 7'b0100100) begin
          fails++; $display("FAIL lastwins_digit d=%0d got seg=%b want 0100100", e_dig, seg);
        end
        tests++;
      end
      if (e_tick) in_new = 1'b1;
    end
  endtask

  task automatic test_back_to_back_boundary();
    logic [3:0] order [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    advance_to(FRAME - 1);
    load = 1'b1; value = 16'h8888; decimal_point = 4'b0000;
    step();
    load = 1'b0;
    if (frame_tick !== 1'b1) begin
      fails++; $display("FAIL bnd_tick got %b want 1", frame_tick);
    end
    tests++;
    for (int k = 0; k < int'(FRAME); k++) begin
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL bnd_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
      if (e_pos == 4) begin
        if ({an, seg} !== {order[e_dig], 7'b0000000}) begin
          fails++; $display("FAIL bnd_digit d=%0d got an=%b seg=%b want an=%b seg=0000000", e_dig, an, seg, order[e_dig]);
        end
        tests++;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    advance_to(12);
    load = 1'b1; value = 16'h3C3C; decimal_point = 4'b1111;
    step();
    load = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    if ({an, seg, dp, frame_tick} !== 13'b1111_1111111_1_0) begin
      fails++; $display("FAIL async_assert got an=%b seg=%b dp=%b tick=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    tests++;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 2 * int'(FRAME); k++) begin
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL async_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
      if (e_pos == 4 && e_dig == 0) begin
        if ({an, seg, dp} !== 12'b1110_1000000_1) begin
          fails++; $display("FAIL async_zero got an=%b seg=%b dp=%b want 1110 1000000 1", an, seg, dp);
        end
        tests++;
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] want_a [4];
    logic [11:0] want_b [4];
`ifdef LEADING_ZERO_BLANK_EN
    want_a = '{12'b1110_0010010_1, 12'b1111_1111111_1, 12'b1111_1111111_1, 12'b1111_1111111_1};
    want_b = '{12'b1110_0010010_1, 12'b1101_1000000_0, 12'b1111_1111111_1, 12'b1111_1111111_1};
`else
    want_a = '{12'b1110_0010010_1, 12'b1101_1000000_1, 12'b1011_1000000_1, 12'b0111_1000000_1};
    want_b = '{12'b1110_0010010_1, 12'b1101_1000000_0, 12'b1011_1000000_1, 12'b0111_1000000_1};
`endif
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      advance_to(10);
      load = 1'b1; value = 16'h0005; decimal_point = (pass == 0) ? 4'b0000 : 4'b0010;
      step();
      load = 1'b0;
      advance_to(0);
      for (int k = 0; k < int'(FRAME); k++) begin
        step();
        if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
          fails++; $display("FAIL lzb_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
        end
        tests++;
        if (e_pos == 4) begin
          if ({an, seg, dp} !== ((pass == 0) ? want_a[e_dig] : want_b[e_dig])) begin
            fails++; $display("FAIL lzb_digit pass=%0d d=%0d got an=%b seg=%b dp=%b want %b", pass, e_dig, an, seg, dp, (pass == 0) ? want_a[e_dig] : want_b[e_dig]);
          end
          tests++;
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      decimal_point = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        fails++; $display("FAIL random_model cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      tests++;
      if ($countones(~an) > 1) begin
        fails++; $display("FAIL random_onehot cyc=%0d got an=%b want at most one low", cyc, an);
      end
      tests++;
    end
    load = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0; load = 1'b0; value = '0; decimal_point = '0;
    model_reset();
    test_reset();
    test_load_mid_frame();
    test_last_wins();
    test_back_to_back_boundary();
    test_async_reset();
    test_leading_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
